// File: rtl/wb_config_loader_pkg.sv
// Shared types and constants for the Wishbone configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`timescale 1ns/1ps
package wb_config_loader_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_REQ  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Byte select driven during every write: full 32-bit words only.
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // Stream bytes packed into one Wishbone word.
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/wb_config_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
// Latency: word_dat holds the full word the cycle after the last byte is accepted.
// Backpressure: consumes a byte only when in_vld && in_rdy; in_rdy is supplied by the owner.
//
// Ports: clk/rst_n, clr (restart at byte 0), in_vld/in_rdy/in_dat (byte stream),
//        word_vld (comb: current accepted byte completes the word), word_dat (assembled word).
`timescale 1ns/1ps
module byte_packer
    import wb_config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_vld,
    input  logic        in_rdy,
    input  logic [7:0]  in_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    localparam int IDXW = $clog2(BYTES_PER_WORD);

    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic            take;

    assign take     = in_vld && in_rdy;
    assign word_vld = take && (idx_q == IDXW'(BYTES_PER_WORD - 1));
    assign word_dat = word_q;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr) begin
            // Old lanes are never read before being overwritten, so only the index restarts.
            idx_d = '0;
        end else if (take) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (idx_q == IDXW'(i)) begin
                    word_d[8*i +: 8] = in_dat;
                end
            end
            // Index wraps naturally to 0 after the last lane.
            idx_d = idx_q + IDXW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/wb_config_loader.sv
// Wishbone initiator that packs a byte stream into words and writes them to consecutive addresses.
// Latency: start->in_ready 1 cycle; 4th byte->stb 1 cycle; ack->next FILL 1 cycle (5 cycles/word best case).
// Backpressure: in_ready only in FILL; stream is stalled while a write is outstanding or when idle.
//
// Ports: wb_clk_i/wb_rst_ni, start, in_valid/in_ready/in_data (byte stream),
//        wbm_* (Wishbone write master), busy, done (pulse), error (sticky), checksum.
// Optional feature macro: WB_CONFIG_LOADER_CHECKSUM_EN (running sum of acked words on checksum).
`timescale 1ns/1ps
module wb_config_loader
    import wb_config_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_WORDS = 16,
    parameter int          TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_data_o,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    localparam int WCW = $clog2(NUM_WORDS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [WCW-1:0]  word_idx_q, word_idx_d;
    logic [TCW-1:0]  to_cnt_q, to_cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic            error_q, error_d;
    logic            done_q, done_d;
    logic            req_q, req_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;

    logic            start_acc;
    logic            wr_ack;
    logic            word_vld;
    logic [31:0]     word_dat;

    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign wr_ack    = (state_q == ST_REQ) && wbm_ack_i;

    byte_packer u_packer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .clr      (start_acc),
        .in_vld   (in_valid),
        .in_rdy   (rdy_q),
        .in_dat   (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        to_cnt_d   = to_cnt_q;
        addr_d     = addr_q;
        error_d    = error_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_FILL;
                    word_idx_d = '0;
                    to_cnt_d   = '0;
                    addr_d     = BASE_ADDR;
                    error_d    = 1'b0;
                end
            end
            ST_FILL: begin
                if (word_vld) begin
                    state_d  = ST_REQ;
                    to_cnt_d = '0;
                end
            end
            ST_REQ: begin
                // Ack is checked first so a write acked on the timeout cycle still counts.
                if (wbm_ack_i) begin
                    to_cnt_d   = '0;
                    addr_d     = addr_q + 32'd4;
                    word_idx_d = word_idx_q + WCW'(1);
                    if (word_idx_q == WCW'(NUM_WORDS - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (to_cnt_q + TCW'(1) == TCW'(TIMEOUT)) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags are decoded from the next state so every output comes straight off a flop.
    assign req_d  = (state_d == ST_REQ);
    assign rdy_d  = (state_d == ST_FILL);
    assign busy_d = req_d || rdy_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            to_cnt_q   <= '0;
            addr_q     <= BASE_ADDR;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            to_cnt_q   <= to_cnt_d;
            addr_q     <= addr_d;
            error_q    <= error_d;
            done_q     <= done_d;
            req_q      <= req_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

`ifdef WB_CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (start_acc) begin
            cks_d = '0;
        end else if (wr_ack) begin
            cks_d = cks_q + word_dat;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    // Ack qualifier only feeds the checksum adder; keep it referenced for the disabled build.
    logic unused_wr_ack;
    assign unused_wr_ack = wr_ack;
    assign checksum      = '0;
`endif

    assign wbm_cyc_o  = req_q;
    assign wbm_stb_o  = req_q;
    assign wbm_we_o   = req_q;
    assign wbm_sel_o  = req_q ? WB_SEL_ALL : 4'h0;
    assign wbm_addr_o = addr_q;
    assign wbm_data_o = word_dat;
    assign in_ready   = rdy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_wb_config_loader.sv
// Directed self-checking bench for wb_config_loader (NUM_WORDS=2, TIMEOUT=4).
// Latency: n/a.
// Backpressure: slave ack delay and stream gaps are driven per vector.
`timescale 1ns/1ps
module tb_wb_config_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          NW   = 2;
    localparam int          TO   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_addr_o, wbm_data_o;
    logic        wbm_ack_i = 1'b0;
    logic        busy, done, error;
    logic [31:0] checksum;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [31:0] exp_addr = BASE;
    logic [31:0] exp_cks  = 32'h0;

    always #5 clk = ~clk;

    wb_config_loader #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_addr_o (wbm_addr_o),
        .wbm_data_o (wbm_data_o),
        .wbm_ack_i  (wbm_ack_i),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = BASE;
        exp_cks  = 32'h0;
        check("start_in_ready", {31'b0, in_ready}, 32'd1);
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_error_clr", {31'b0, error}, 32'd0);
        check("start_addr", wbm_addr_o, BASE);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int g = 0; g < 50 && !ok; g++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("byte_accept", {31'b0, ok}, 32'd1);
        for (int g = 0; g < gap; g++) begin
            if (poke && g == 0) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit poke);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (i < 3) ? gap : 0, poke);
        end
        check("stb_rise", {31'b0, wbm_stb_o}, 32'd1);
    endtask

    task automatic do_word(input logic [31:0] w, input int gap, input int delay,
                           input bit last, input bit poke);
        send_word(w, gap, poke);
        for (int d = 0; d <= delay; d++) begin
            if (poke && d == 0 && delay > 0) start = 1'b1;
            if (d == delay) wbm_ack_i = 1'b1;
            check("req_addr", wbm_addr_o, exp_addr);
            check("req_data", wbm_data_o, w);
            check("req_sel", {28'b0, wbm_sel_o}, 32'hF);
            check("req_cyc_we", {30'b0, wbm_cyc_o, wbm_we_o}, 32'd3);
            tick();
            start = 1'b0;
            wbm_ack_i = 1'b0;
        end
        exp_addr = exp_addr + 32'd4;
`ifdef WB_CONFIG_LOADER_CHECKSUM_EN
        exp_cks = exp_cks + w;
`endif
        check("stb_fall", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("addr_inc", wbm_addr_o, exp_addr);
        check("checksum", checksum, exp_cks);
        if (last) begin
            check("done_pulse", {31'b0, done}, 32'd1);
            check("done_busy", {30'b0, busy, in_ready}, 32'd0);
            tick();
            check("done_drop", {31'b0, done}, 32'd0);
        end else begin
            check("refill_ready", {31'b0, in_ready}, 32'd1);
            check("no_early_done", {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        int cnt;

        // Reset state
        tick();
        tick();
        check("rst_bus", {28'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o, 1'b0} | {28'b0, wbm_sel_o}, 32'd0);
        check("rst_addr", wbm_addr_o, BASE);
        check("rst_data", wbm_data_o, 32'h0);
        check("rst_flags", {28'b0, in_ready, busy, done, error}, 32'd0);
        check("rst_checksum", checksum, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_flags", {28'b0, in_ready, busy, done, error}, 32'd0);

        // Zero-wait slave, two words
        done_cnt = 0;
        do_start();
        do_word(32'h0403_0201, 0, 0, 1'b0, 1'b0);
        do_word(32'h0807_0605, 0, 0, 1'b1, 1'b0);
        check("t1_done_count", done_cnt, 32'd1);
        check("t1_error", {31'b0, error}, 32'd0);
        // Bytes offered in DONE are refused
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        check("done_no_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // Slave delays ack 3 cycles; ack lands on the timeout cycle and must win
        do_start();
        do_word(32'hDEAD_BEEF, 0, 3, 1'b0, 1'b0);
        do_word(32'hCAFE_F00D, 0, 1, 1'b1, 1'b0);
        check("t2_error", {31'b0, error}, 32'd0);

        // Slave never acks
        do_start();
        send_word(32'h1234_5678, 0, 1'b0);
        cnt = 0;
        while (wbm_stb_o && cnt < 20) begin
            cnt++;
            tick();
        end
        check("to_req_cycles", cnt, TO);
        check("to_error", {31'b0, error}, 32'd1);
        check("to_bus_idle", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("to_busy", {31'b0, busy}, 32'd0);
        tick();
        check("to_error_sticky", {31'b0, error}, 32'd1);

        // Restart clears error; bursty stream with start pokes while busy
        done_cnt = 0;
        do_start();
        do_word(32'h4433_2211, 2, 1, 1'b0, 1'b1);
        do_word(32'h8877_6655, 2, 1, 1'b1, 1'b1);
        check("t4_done_count", done_cnt, 32'd1);
        check("t4_error", {31'b0, error}, 32'd0);

        // Asynchronous reset while a write is outstanding
        do_start();
        send_word(32'h0BAD_F00D, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bus_drop", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_addr", wbm_addr_o, BASE);
        check("arst_flags", {28'b0, in_ready, busy, done, error}, 32'd0);
        check("arst_checksum", checksum, 32'h0);

        // Checksum wrap-around
        do_start();
        do_word(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        do_word(32'h0000_0002, 0, 0, 1'b1, 1'b0);
`ifdef WB_CONFIG_LOADER_CHECKSUM_EN
        check("cks_wrap", checksum, 32'h0000_0001);
`else
        check("cks_off", checksum, 32'h0000_0000);
`endif
        tick();
        check("cks_hold", checksum, exp_cks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_config_loader.md
# wb_config_loader

Wishbone initiator that loads the fabric configuration through the configurator's Wishbone slave port. It accepts a byte stream (e.g. from GPIO or a SPI front end) on a valid/ready interface and packs bytes into 32-bit words. Each word goes out as a single Wishbone write to consecutive addresses from `BASE_ADDR`, and the block reports completion or an ack timeout. It sits beside the configurator and shares its clock; it is the initiator end of the configurator's Wishbone interface.

## Interface
- `BASE_ADDR`, 32'h3000_0000, address of the first word written.
- `NUM_WORDS`, 16, words per load (≥1); word counter width is `$clog2(NUM_WORDS+1)`.
- `TIMEOUT`, 255, cycles to wait for `wbm_ack_i` per write before aborting (≥1).

Ports:
- `wb_clk_i` in 1: fabric/Wishbone clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a load. Sampled only in IDLE, DONE or ERR.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone bus cycle, strobe and write enable.
- `wbm_sel_o` out 4: byte select, 4'hF during writes.
- `wbm_addr_o` out 32, `wbm_data_o` out 32: write address and data.
- `wbm_ack_i` in 1: slave acknowledge.
- `busy` out 1: high in FILL or REQ.
- `done` out 1: one-cycle pulse when the last word is acked.
- `error` out 1: sticky after a timeout; cleared by the next accepted `start`.
- `checksum` out 32: see Configuration.

## Operation
- States:
  - IDLE.
  - FILL: collecting the 4 bytes of the current word.
  - REQ: Wishbone write outstanding.
  - DONE: load finished.
  - ERR: load aborted.
- IDLE/DONE/ERR + `start`:
  - go to FILL;
  - word index = 0, byte index = 0;
  - clear `error`;
  - `wbm_addr_o` = `BASE_ADDR`.
- FILL:
  - `in_ready` = 1;
  - each accepted byte goes into word bits [8*i+7:8*i], little-endian, byte index i.
  - On the 4th byte, go to REQ.
- REQ:
  - `wbm_cyc_o` = `wbm_stb_o` = `wbm_we_o` = 1, `wbm_sel_o` = 4'hF;
  - address and data are held stable until ack.
- Ack sampled high in REQ:
  - drop cyc/stb next cycle;
  - timeout counter = 0;
  - `wbm_addr_o` += 4;
  - word index += 1.
  - If word index was `NUM_WORDS`-1, go to DONE and pulse `done`; otherwise go to FILL.
- Timeout:
  - the counter increments each REQ cycle without ack;
  - reaching `TIMEOUT` → ERR, drop cyc/stb, set `error`.
  - An ack arriving in the same cycle as the timeout wins; the write counts.
- `in_ready` = 0 outside FILL. Bytes offered then are not consumed.
- `start` while busy is ignored.
- Address wraps modulo 2^32; no special handling.

## Timing
- Reset values:
  - all Wishbone outputs 0, address `BASE_ADDR`;
  - `in_ready`, `busy`, `done`, `error` = 0;
  - `checksum` = 0; state IDLE.
- All outputs are registered.
- `start` at edge N → FILL and `in_ready` = 1 from N+1.
- 4th byte accepted at edge M → `wbm_stb_o` = 1 from M+1.
- Ack sampled at edge K → `wbm_stb_o` = 0 and `in_ready` = 1 from K+1. This gives one idle bus cycle minimum between writes.
- Best case: 5 cycles per word (4 bytes + 1 ack cycle with a zero-wait slave).
- `done` is high only for the cycle after the final ack.
- Asynchronous reset mid-transaction drops cyc/stb immediately and discards the partial word.

## Configuration
- `WB_CONFIG_LOADER_CHECKSUM_EN`:
  - Defined: `checksum` is the running 32-bit wrap-around sum of all acked words. It is cleared on accepted `start` and holds its value in DONE/ERR.
  - Undefined: `checksum` is tied to 0 and no adder is built.

## Structure
- Shared package `wb_config_loader_pkg` holds:
  - state enum (IDLE, FILL, REQ, DONE, ERR);
  - `WB_SEL_ALL` = 4'hF;
  - `BYTES_PER_WORD` = 4.
- Sub-module `byte_packer`: byte index counter plus 32-bit shift/assemble register with a valid/ready input and a `word_valid` output. The FSM, timeout counter and Wishbone drive stay in the top.

## Test plan
- Zero-wait slave, `NUM_WORDS`=2, bytes 01 02 03 04 05 06 07 08:
  - writes 32'h04030201 @ 3000_0000, then 32'h08070605 @ 3000_0004;
  - `done` pulses once; `error` = 0.
- Slave delays ack 3 cycles: addr/data/sel held stable all 4 REQ cycles; stb falls the cycle after ack.
- Slave never acks, `TIMEOUT`=4:
  - ERR after 4 REQ cycles, cyc/stb = 0, `error` = 1;
  - next `start` clears `error`.
- Bursty `in_valid` (gaps of 2 cycles) and `start` pulsed while busy: word contents unchanged, extra `start` ignored.
- Reset asserted during REQ: cyc/stb drop asynchronously; after release state is IDLE, address `BASE_ADDR`.
- With `WB_CONFIG_LOADER_CHECKSUM_EN`, words FFFFFFFF and 00000002: `checksum` = 32'h00000001. Without the macro: `checksum` = 0.
